// File: rtl/led_status_pkg.sv
// Shared mode encoding for the LED status controller.
package led_status_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF     = 2'b00;
  localparam mode_t MODE_STEADY  = 2'b01;
  localparam mode_t MODE_BLINK   = 2'b10;
  localparam mode_t MODE_BREATHE = 2'b11;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: mode decode and PWM compare, unregistered.
module led_pwm_channel
  import led_status_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  mode_t               mode_i,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic                phase_i,
  input  logic [PWM_BITS-1:0] lvl_i,
  input  logic                force_i,
  output logic                raw_o
);

  logic [PWM_BITS-1:0] eff;
  logic                on;

  always_comb begin
    eff = phase_i ? ~lvl_i : lvl_i;
    on  = 1'b0;
    unique case (1'b1)
      (mode_i == MODE_OFF):     on = 1'b0;
      (mode_i == MODE_STEADY):  on = cnt_i < duty_i;
      (mode_i == MODE_BLINK):   on = (cnt_i < duty_i) & ~phase_i;
      (mode_i == MODE_BREATHE): on = cnt_i < eff;
      default:                  on = 1'b0;
    endcase
  end

  assign raw_o = on | force_i;

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel LED status controller: shared timebase, hold window,
// per-channel PWM with registered outputs.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 12000,
  parameter int BLINK_BITS = 9,
  parameter int HOLD_MAX   = 3072,
  parameter int ACT_TICKS  = 1024,
  parameter int ACT_CH     = 0
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         sleep_i,
  input  logic                         pu_i,
  input  logic [2*CHANNELS-1:0]        mode_i,
  input  logic [PWM_BITS*CHANNELS-1:0] duty_i,
  output logic [CHANNELS-1:0]          pwm_o,
  output logic                         override_o
);

  localparam int PRE_W  = $clog2(PRESCALE);
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_RLD = HOLD_W'(HOLD_MAX - ACT_TICKS);

  logic [1:0]                         sync_q;
  logic                               sleep_s;
  logic                               tick;
  logic [PRE_W-1:0]                   pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_BITS-1:0]              blink_cnt_q, blink_cnt_d;
  logic [HOLD_W-1:0]                  hold_cnt_q, hold_cnt_d;
  mode_t [CHANNELS-1:0]               mode_sh_q, mode_sh_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  duty_sh_q, duty_sh_d;
  logic [CHANNELS-1:0]                raw;
  logic [CHANNELS-1:0]                pwm_q;
  logic                               ovr_d, ovr_q;
  logic                               phase;
  logic [PWM_BITS-1:0]                lvl;

  assign sleep_s = sync_q[1];
  assign phase   = blink_cnt_q[BLINK_BITS-1];
  assign lvl     = blink_cnt_q[BLINK_BITS-2 -: PWM_BITS];

  always_comb begin
    tick        = (pre_cnt_q == PRE_LAST);
    pre_cnt_d   = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    blink_cnt_d = tick ? blink_cnt_q + BLINK_BITS'(1) : blink_cnt_q;

    // Reload only from saturation, so activity never extends an open window.
    hold_cnt_d = hold_cnt_q;
    if (hold_cnt_q == HOLD_TOP) begin
      if (!sleep_s) hold_cnt_d = HOLD_RLD;
    end else if (tick) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end

    mode_sh_d = mode_sh_q;
    duty_sh_d = duty_sh_q;
    if (&pwm_cnt_q) begin
      mode_sh_d = mode_i;
      duty_sh_d = duty_i;
    end

    ovr_d = ~pu_i | (hold_cnt_q != HOLD_TOP);
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .mode_i (mode_sh_q[n]),
      .duty_i (duty_sh_q[n]),
      .cnt_i  (pwm_cnt_q),
      .phase_i(phase),
      .lvl_i  (lvl),
      .force_i(ovr_d & (n == ACT_CH)),
      .raw_o  (raw[n])
    );
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q      <= '0;
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      hold_cnt_q  <= '0;
      mode_sh_q   <= '0;
      duty_sh_q   <= '0;
      pwm_q       <= '0;
      ovr_q       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], sleep_i};
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      mode_sh_q   <= mode_sh_d;
      duty_sh_q   <= duty_sh_d;
      pwm_q       <= raw;
      ovr_q       <= ovr_d;
    end
  end

  assign pwm_o      = pwm_q;
  assign override_o = ovr_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with a small timebase.
module tb_led_status_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sleep = 1'b1;
  logic        pu = 1'b1;
  logic [5:0]  mode = '0;
  logic [11:0] duty = '0;
  logic [2:0]  pwm;
  logic        ovr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  led_status_ctrl #(
    .CHANNELS  (3),
    .PWM_BITS  (4),
    .PRESCALE  (4),
    .BLINK_BITS(5),
    .HOLD_MAX  (8),
    .ACT_TICKS (4),
    .ACT_CH    (0)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .sleep_i   (sleep),
    .pu_i      (pu),
    .mode_i    (mode),
    .duty_i    (duty),
    .pwm_o     (pwm),
    .override_o(ovr)
  );

  always #5 clk = ~clk;

  // Edges since reset release; equals the DUT pwm counter phase.
  always @(posedge clk or negedge rstn)
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] m,
                        input logic [3:0] d);
    mode[2*ch +: 2] = m;
    duty[4*ch +: 4] = d;
  endtask

  task automatic align(input int m, input int r);
    int n;
    n = 0;
    while ((cyc % m) != r && n < m) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pwm !== 3'b000) begin
      errors++;
      $display("FAIL reset_pwm got %b exp 000", pwm);
    end
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovr got %b exp 0", ovr);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_startup();
    int hi;
    hi = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      hi += int'(ovr);
      if (k == 1) begin
        checks++;
        if (ovr !== 1'b1 || pwm[0] !== 1'b1) begin
          errors++;
          $display("FAIL startup_first ovr %b pwm0 %b exp 1 1", ovr, pwm[0]);
        end
        checks++;
        if (pwm[2:1] !== 2'b00) begin
          errors++;
          $display("FAIL startup_shadow_off got %b exp 00", pwm[2:1]);
        end
      end
      if (k == 33) begin
        checks++;
        if (ovr !== 1'b0 || pwm[0] !== 1'b0) begin
          errors++;
          $display("FAIL startup_expire ovr %b pwm0 %b exp 0 0", ovr, pwm[0]);
        end
      end
    end
    checks++;
    if (hi != 32) begin
      errors++;
      $display("FAIL startup_len got %0d exp 32", hi);
    end
  endtask

  task automatic test_steady();
    logic [3:0] d;
    int cnt;
    logic [3:0] tbl [3];
    tbl = '{4'd4, 4'd0, 4'd15};
    for (int t = 0; t < 3; t++) begin
      d = tbl[t];
      set_ch(1, 2'b01, d);
      repeat (20) step();
      cnt = 0;
      repeat (16) begin
        step();
        cnt += int'(pwm[1]);
      end
      checks++;
      if (cnt != int'(d)) begin
        errors++;
        $display("FAIL steady_duty%0d got %0d exp %0d", d, cnt, d);
      end
    end
  endtask

  task automatic test_duty_change();
    int cnt;
    set_ch(1, 2'b01, 4'd4);
    repeat (20) step();
    align(16, 6);
    duty[7:4] = 4'd12;
    cnt = 0;
    repeat (10) begin
      step();
      cnt += int'(pwm[1]);
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL duty_old_tail got %0d exp 0", cnt);
    end
    cnt = 0;
    repeat (16) begin
      step();
      cnt += int'(pwm[1]);
    end
    checks++;
    if (cnt != 12) begin
      errors++;
      $display("FAIL duty_new_period got %0d exp 12", cnt);
    end
  endtask

  task automatic test_blink();
    int on_cnt;
    int off_cnt;
    set_ch(1, 2'b00, 4'd0);
    set_ch(2, 2'b10, 4'd8);
    repeat (20) step();
    align(128, 0);
    on_cnt = 0;
    repeat (64) begin
      step();
      on_cnt += int'(pwm[2]);
    end
    off_cnt = 0;
    repeat (64) begin
      step();
      off_cnt += int'(pwm[2]);
    end
    checks++;
    if (on_cnt != 32) begin
      errors++;
      $display("FAIL blink_on_half got %0d exp 32", on_cnt);
    end
    checks++;
    if (off_cnt != 0) begin
      errors++;
      $display("FAIL blink_off_half got %0d exp 0", off_cnt);
    end
  endtask

  task automatic test_breathe();
    int cnt;
    int exp_t [8];
    exp_t = '{0, 5, 10, 15, 12, 9, 6, 3};
    set_ch(2, 2'b00, 4'd0);
    set_ch(1, 2'b11, 4'd0);
    repeat (20) step();
    align(128, 0);
    for (int p = 0; p < 8; p++) begin
      cnt = 0;
      repeat (16) begin
        step();
        cnt += int'(pwm[1]);
      end
      checks++;
      if (cnt != exp_t[p]) begin
        errors++;
        $display("FAIL breathe_p%0d got %0d exp %0d", p, cnt, exp_t[p]);
      end
    end
    set_ch(1, 2'b00, 4'd0);
  endtask

  task automatic test_pu_low();
    step();
    pu = 1'b0;
    step();
    checks++;
    if (ovr !== 1'b1 || pwm[0] !== 1'b1) begin
      errors++;
      $display("FAIL pu_low ovr %b pwm0 %b exp 1 1", ovr, pwm[0]);
    end
    pu = 1'b1;
    step();
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL pu_high got %b exp 0", ovr);
    end
  endtask

  task automatic test_activity_pulse();
    int hi;
    int e;
    align(4, 1);
    e = cyc;
    sleep = 1'b0;
    step();
    sleep = 1'b1;
    step();
    step();
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL act_edge3 got %b exp 0 at %0d", ovr, cyc - e);
    end
    step();
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL act_edge4 got %b exp 1", ovr);
    end
    hi = 1;
    repeat (19) begin
      step();
      hi += int'(ovr);
    end
    checks++;
    if (hi != 16) begin
      errors++;
      $display("FAIL act_window got %0d exp 16", hi);
    end
  endtask

  task automatic test_activity_hold();
    int n;
    int first_low;
    sleep = 1'b0;
    n = 0;
    while (ovr !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    n = 0;
    while (ovr !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL hold_expiry got %b exp 0 (timeout)", ovr);
    end
    first_low = cyc;
    step();
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL hold_one_low got %b exp 1", ovr);
    end
    n = 0;
    while (ovr !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (cyc - first_low != 16) begin
      errors++;
      $display("FAIL hold_period got %0d exp 16", cyc - first_low);
    end
    sleep = 1'b1;
    repeat (40) step();
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got %b exp 0", ovr);
    end
  endtask

  task automatic test_reset_mid_blink();
    set_ch(1, 2'b01, 4'd4);
    set_ch(2, 2'b10, 4'd8);
    repeat (40) step();
    rstn = 1'b0;
    #1;
    checks++;
    if (pwm !== 3'b000) begin
      errors++;
      $display("FAIL midrst_pwm got %b exp 000", pwm);
    end
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ovr got %b exp 0", ovr);
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    test_startup();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_steady();
    test_duty_change();
    test_blink();
    test_breathe();
    test_pu_low();
    test_activity_pulse();
    test_activity_hold();
    test_reset_mid_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
